// File: rtl/wd_service_master_if.sv
// ---------------------------------------------------------------------------
// wd_service_master_if
// Bundles the control inputs, watchdog ABUS/DBUS write bus and status
// outputs of wd_service_master.
//   master modport : the service master's view (drives abus/dbus/status)
//   slave  modport : the host / watchdog side (drives control, wdfail)
// Signals:
//   start, stop, healthy   host control and health inputs
//   fw_cfg, rl_cfg [15:0]  configuration words for addresses 2'b00 / 2'b01
//   wdfail                 watchdog fail indication
//   abus [1:0], dbus[15:0] watchdog write bus
//   busy, running, fault, skip   status outputs
//   srv_count [15:0]       completed service writes (only with WD_SRV_COUNT_EN)
// Optional feature macro: WD_SRV_COUNT_EN
// ---------------------------------------------------------------------------
interface wd_service_master_if;
    logic        start;
    logic        stop;
    logic        healthy;
    logic [15:0] fw_cfg;
    logic [15:0] rl_cfg;
    logic        wdfail;
    logic [1:0]  abus;
    logic [15:0] dbus;
    logic        busy;
    logic        running;
    logic        fault;
    logic        skip;
`ifdef WD_SRV_COUNT_EN
    logic [15:0] srv_count;

    modport master (
        input  start, stop, healthy, fw_cfg, rl_cfg, wdfail,
        output abus, dbus, busy, running, fault, skip, srv_count
    );
    modport slave (
        output start, stop, healthy, fw_cfg, rl_cfg, wdfail,
        input  abus, dbus, busy, running, fault, skip, srv_count
    );
`else
    modport master (
        input  start, stop, healthy, fw_cfg, rl_cfg, wdfail,
        output abus, dbus, busy, running, fault, skip
    );
    modport slave (
        output start, stop, healthy, fw_cfg, rl_cfg, wdfail,
        input  abus, dbus, busy, running, fault, skip
    );
`endif
endinterface

// File: rtl/wd_service_master.sv
// ---------------------------------------------------------------------------
// wd_service_master
// Host-side bus master for the watchdog. On START it writes the frame-window
// and reset-limit words and the INIT command, then services the watchdog
// every SRV_PERIOD cycles while HEALTHY is high. Every write is a 3-cycle
// transaction: unlock-key cycle, data cycle, idle gap. WDFAIL aborts
// everything and parks the block in FAILED until reset.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous reset, active-low
//   bus   wd_service_master_if.master (control inputs, ABUS/DBUS, status)
// Optional feature macro: WD_SRV_COUNT_EN adds bus.srv_count, a saturating
//   count of completed service writes, cleared on reset and accepted START.
// ---------------------------------------------------------------------------
module wd_service_master #(
    parameter logic [15:0] UNLOCK_KEY = 16'hA5C3,
    parameter int unsigned SRV_PERIOD = 1000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    wd_service_master_if.master        bus
);
    typedef enum logic [2:0] {IDLE, CFG_FW, CFG_RL, CFG_INIT, RUN, SRV, FAILED} state_t;
    typedef enum logic [1:0] {PH_K, PH_D, PH_G} phase_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRV_PERIOD - 1);

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stop_pend_q, stop_pend_d;
    logic [15:0]       fw_q, rl_q;
    logic              load_cfg;

    logic [1:0]        abus_q, abus_d;
    logic [15:0]       dbus_q, dbus_d;
    logic              busy_q, busy_d;
    logic              running_q, running_d;
    logic              fault_q, fault_d;
    logic              skip_q, skip_d;

    logic [1:0]        wr_addr;
    logic [15:0]       wr_data;

    // Next-state logic. The registered outputs are decoded from the *next*
    // state/phase so they line up with the state they describe.
    always_comb begin
        // NOTE: every variable gets a default before any branch; otherwise a
        // path that skips an assignment infers a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = '0;
        stop_pend_d = stop_pend_q;
        skip_d      = 1'b0;
        load_cfg    = 1'b0;

        if (bus.wdfail) begin
            state_d = FAILED;
        end else begin
            case (state_q)
                IDLE: begin
                    stop_pend_d = 1'b0;
                    if (bus.start && !bus.stop) begin
                        state_d  = CFG_FW;
                        phase_d  = PH_K;
                        load_cfg = 1'b1;
                    end
                end
                CFG_FW, CFG_RL, CFG_INIT, SRV: begin
                    // STOP may be a short pulse; remember it until the gap cycle.
                    if (bus.stop) stop_pend_d = 1'b1;
                    case (phase_q)
                        PH_K:    phase_d = PH_D;
                        PH_D:    phase_d = PH_G;
                        default: begin
                            phase_d = PH_K;
                            if (bus.stop || stop_pend_q) begin
                                state_d     = IDLE;
                                stop_pend_d = 1'b0;
                            end else begin
                                case (state_q)
                                    CFG_FW:  state_d = CFG_RL;
                                    CFG_RL:  state_d = CFG_INIT;
                                    default: state_d = RUN;
                                endcase
                            end
                        end
                    endcase
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        if (bus.healthy) begin
                            state_d = SRV;
                            phase_d = PH_K;
                        end else begin
                            skip_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = FAILED;
            endcase
        end

        case (state_d)
            CFG_FW:   begin wr_addr = 2'b00; wr_data = fw_q;     end
            CFG_RL:   begin wr_addr = 2'b01; wr_data = rl_q;     end
            CFG_INIT: begin wr_addr = 2'b11; wr_data = 16'h0001; end
            default:  begin wr_addr = 2'b11; wr_data = 16'h0002; end
        endcase

        busy_d = 1'b0;
        abus_d = 2'b00;
        dbus_d = 16'h0000;
        if (state_d inside {CFG_FW, CFG_RL, CFG_INIT, SRV}) begin
            busy_d = 1'b1;
            if (phase_d != PH_G) begin
                abus_d = wr_addr;
                dbus_d = (phase_d == PH_K) ? UNLOCK_KEY : wr_data;
            end
        end
        running_d = state_d inside {RUN, SRV};
        fault_d   = (state_d == FAILED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            phase_q     <= PH_K;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            fw_q        <= 16'h0000;
            rl_q        <= 16'h0000;
            abus_q      <= 2'b00;
            dbus_q      <= 16'h0000;
            busy_q      <= 1'b0;
            running_q   <= 1'b0;
            fault_q     <= 1'b0;
            skip_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            if (load_cfg) begin
                fw_q <= bus.fw_cfg;
                rl_q <= bus.rl_cfg;
            end
            abus_q      <= abus_d;
            dbus_q      <= dbus_d;
            busy_q      <= busy_d;
            running_q   <= running_d;
            fault_q     <= fault_d;
            skip_q      <= skip_d;
        end
    end

    assign bus.abus    = abus_q;
    assign bus.dbus    = dbus_q;
    assign bus.busy    = busy_q;
    assign bus.running = running_q;
    assign bus.fault   = fault_q;
    assign bus.skip    = skip_q;

`ifdef WD_SRV_COUNT_EN
    logic [15:0] srv_count_q;

    // Counts on entry to the gap cycle, so an aborted service never counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            srv_count_q <= 16'h0000;
        end else if (load_cfg) begin
            srv_count_q <= 16'h0000;
        end else if (state_d == SRV && phase_d == PH_G && srv_count_q != 16'hFFFF) begin
            srv_count_q <= srv_count_q + 16'd1;
        end
    end

    assign bus.srv_count = srv_count_q;
`endif
endmodule

// File: tb/tb_wd_service_master.sv
// ---------------------------------------------------------------------------
// tb_wd_service_master
// Self-checking bench for wd_service_master with SRV_PERIOD=20. Expected
// bus writes are queued when the stimulus that causes them is applied; a
// negedge monitor pops and compares every non-idle bus cycle.
// Optional feature macro: WD_SRV_COUNT_EN (srv_count checks).
// ---------------------------------------------------------------------------
module tb_wd_service_master;
    localparam logic [15:0] KEY    = 16'hA5C3;
    localparam int          PERIOD = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;

    wd_service_master_if bus_if();

    wd_service_master #(
        .UNLOCK_KEY (KEY),
        .SRV_PERIOD (PERIOD),
        .CNT_W      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [17:0] exp_q[$];

    logic [17:0] cfg_tbl [9] = '{
        {2'b00, 16'hA5C3}, {2'b00, 16'h0123}, 18'h0,
        {2'b01, 16'hA5C3}, {2'b01, 16'h0045}, 18'h0,
        {2'b11, 16'hA5C3}, {2'b11, 16'h0001}, 18'h0
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [1:0] a, input logic [15:0] d);
        exp_q.push_back({a, KEY});
        exp_q.push_back({a, d});
    endtask

    // Steps until a service key cycle is on the bus; returns the step count
    // (a timeout returns 200, which never matches an expected gap).
    task automatic wait_srv_k(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(bus_if.abus == 2'b11 && bus_if.dbus == KEY && bus_if.running) && n < 200);
    endtask

    always @(negedge clk) begin
        logic [17:0] e;
        if (bus_if.abus != 2'b00 || bus_if.dbus != 16'h0000) begin
            if (exp_q.size() == 0) begin
                check("bus_unexpected", {14'd0, bus_if.abus, bus_if.dbus}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("bus_write", {14'd0, bus_if.abus, bus_if.dbus}, {14'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        bus_if.start   = 1'b0;
        bus_if.stop    = 1'b0;
        bus_if.healthy = 1'b1;
        bus_if.fw_cfg  = 16'h0000;
        bus_if.rl_cfg  = 16'h0000;
        bus_if.wdfail  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_abus",    bus_if.abus,    0);
        check("rst_dbus",    bus_if.dbus,    0);
        check("rst_busy",    bus_if.busy,    0);
        check("rst_running", bus_if.running, 0);
        check("rst_fault",   bus_if.fault,   0);
        check("rst_skip",    bus_if.skip,    0);
`ifdef WD_SRV_COUNT_EN
        check("rst_count",   bus_if.srv_count, 0);
`endif
        rst = 1'b1;
        step();

        // Configuration sequence, cycle by cycle; config words change after START
        bus_if.fw_cfg = 16'h0123;
        bus_if.rl_cfg = 16'h0045;
        bus_if.start  = 1'b1;
        push_wr(2'b00, 16'h0123);
        push_wr(2'b01, 16'h0045);
        push_wr(2'b11, 16'h0001);
        step();
        bus_if.start  = 1'b0;
        bus_if.fw_cfg = 16'hFFFF;
        bus_if.rl_cfg = 16'hFFFF;
        for (int i = 0; i < 9; i++) begin
            check("cfg_bus",     {14'd0, bus_if.abus, bus_if.dbus}, {14'd0, cfg_tbl[i]});
            check("cfg_busy",    bus_if.busy,    1);
            check("cfg_running", bus_if.running, 0);
            step();
        end
        check("run_running", bus_if.running, 1);
        check("run_busy",    bus_if.busy,    0);

        // Periodic service, HEALTHY held high
        push_wr(2'b11, 16'h0002);
        wait_srv_k(n);
        check("srv_first_gap", n, PERIOD);
        check("srv_busy", bus_if.busy, 1);
        for (int i = 0; i < 2; i++) begin
            push_wr(2'b11, 16'h0002);
            wait_srv_k(n);
            check("srv_period", n, PERIOD + 3);
        end
        step();
        step();
`ifdef WD_SRV_COUNT_EN
        check("count_after3", bus_if.srv_count, 3);
`endif

        // Unhealthy service point: SKIP pulse, no write
        bus_if.healthy = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus_if.skip && n < 60);
        check("skip_at", n, PERIOD + 1);
        check("skip_busy", bus_if.busy, 0);
        bus_if.healthy = 1'b1;
        step();
        check("skip_pulse_end", bus_if.skip, 0);
        push_wr(2'b11, 16'h0002);
        wait_srv_k(n);
        check("srv_after_skip", n, PERIOD - 1);

        // STOP in RUN
        step();
        step();
`ifdef WD_SRV_COUNT_EN
        check("count_after4", bus_if.srv_count, 4);
`endif
        step();
        check("run_before_stop", bus_if.running, 1);
        bus_if.stop = 1'b1;
        step();
        bus_if.stop = 1'b0;
        check("stop_run_running", bus_if.running, 0);
        check("stop_run_busy",    bus_if.busy,    0);
        step();
        check("idle_running", bus_if.running, 0);

        // STOP during CFG_RL key cycle, START during BUSY ignored
        bus_if.fw_cfg = 16'h1111;
        bus_if.rl_cfg = 16'h2222;
        bus_if.start  = 1'b1;
        push_wr(2'b00, 16'h1111);
        push_wr(2'b01, 16'h2222);
        step();
        bus_if.start = 1'b0;
`ifdef WD_SRV_COUNT_EN
        check("count_cleared", bus_if.srv_count, 0);
`endif
        step();
        step();
        step();
        check("rl_key", {14'd0, bus_if.abus, bus_if.dbus}, {14'd0, 2'b01, KEY});
        bus_if.stop  = 1'b1;
        bus_if.start = 1'b1;
        step();
        bus_if.stop  = 1'b0;
        bus_if.start = 1'b0;
        step();
        check("rl_gap_busy", bus_if.busy, 1);
        step();
        check("stopped_busy",    bus_if.busy,    0);
        check("stopped_running", bus_if.running, 0);
        repeat (3) step();
        check("stopped_stays", bus_if.busy, 0);

        // START and STOP together in IDLE
        bus_if.start = 1'b1;
        bus_if.stop  = 1'b1;
        step();
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        check("start_stop_busy", bus_if.busy, 0);
        repeat (3) step();
        check("start_stop_idle", bus_if.busy, 0);
        check("start_stop_run",  bus_if.running, 0);

        // WDFAIL during the data cycle of a service write
        bus_if.fw_cfg = 16'h0123;
        bus_if.rl_cfg = 16'h0045;
        bus_if.start  = 1'b1;
        push_wr(2'b00, 16'h0123);
        push_wr(2'b01, 16'h0045);
        push_wr(2'b11, 16'h0001);
        step();
        bus_if.start = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus_if.running && n < 50);
        check("run_latency", n, 9);
        push_wr(2'b11, 16'h0002);
        wait_srv_k(n);
        check("fail_srv_gap", n, PERIOD);
        step();
        check("fail_in_d", {14'd0, bus_if.abus, bus_if.dbus}, {14'd0, 2'b11, 16'h0002});
        bus_if.wdfail = 1'b1;
        step();
        bus_if.wdfail = 1'b0;
        check("fail_bus",     {14'd0, bus_if.abus, bus_if.dbus}, 0);
        check("fail_fault",   bus_if.fault,   1);
        check("fail_running", bus_if.running, 0);
        check("fail_busy",    bus_if.busy,    0);
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b1;
        step();
        bus_if.stop  = 1'b0;
        step();
        check("fail_sticky",  bus_if.fault,   1);
        check("fail_nostart", bus_if.busy,    0);
        check("fail_norun",   bus_if.running, 0);
`ifdef WD_SRV_COUNT_EN
        check("count_aborted", bus_if.srv_count, 0);
`endif

        // Reset clears FAULT asynchronously
        #3;
        rst = 1'b0;
        #1;
        check("rst_clears_fault", bus_if.fault, 0);
        step();
        rst = 1'b1;
        step();

        // Reset mid-write: bus returns idle without a clock edge
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        check("midwrite_key", {14'd0, bus_if.abus, bus_if.dbus}, {14'd0, 2'b00, KEY});
        #2;
        rst = 1'b0;
        #1;
        check("midwrite_rst_bus",  {14'd0, bus_if.abus, bus_if.dbus}, 0);
        check("midwrite_rst_busy", bus_if.busy, 0);
        step();
        rst = 1'b1;
        repeat (3) step();
        check("midwrite_idle", bus_if.busy, 0);

        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
